// File: rtl/definitions.sv
// Opcode constants shared by the accumulator core. The ALU, imem loader
// and sequencer all decode against these values.
package definitions;
  localparam logic [3:0] kBRZ = 4'h8;
  localparam logic [3:0] kBRN = 4'h9;
  localparam logic [3:0] kJMP = 4'hA;
endpackage

// File: rtl/pc_seq.sv
// Program sequencer for the accumulator core: PC, run-time branch-offset LUT,
// start/done/timeout handshake and a watchdog cycle counter capped at MAX_CYCLES.
module pc_seq
  import definitions::*;
#(
  parameter int PC_W       = 8,
  parameter int INST_W     = 9,
  parameter int OP_W       = 4,
  parameter int LUT_AW     = 2,
  parameter int OFF_W      = 8,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic [INST_W-1:0] inst,
  input  logic              z,
  input  logic              neg,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [OFF_W-1:0]  lut_din,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
);

  localparam int FLD_W = INST_W - OP_W;
  localparam int LUT_N = 2**LUT_AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               timeout_q, timeout_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic [OFF_W-1:0]   lut_q [LUT_N];

  logic [OP_W-1:0]    op;
  logic [FLD_W-1:0]   field;
  logic               is_jmp, is_halt, taken, at_limit;
  logic signed [OFF_W-1:0] off;
  logic [PC_W-1:0]    off_ext, jmp_tgt;

  assign op       = inst[INST_W-1 -: OP_W];
  assign field    = inst[FLD_W-1:0];
  assign is_jmp   = (op == OP_W'(kJMP));
  assign is_halt  = is_jmp && (field == '0);
  assign taken    = ((op == OP_W'(kBRZ)) && z) || ((op == OP_W'(kBRN)) && neg);
  // Registered LUT read: a same-cycle write is seen by the following branch only.
  assign off      = lut_q[field[LUT_AW-1:0]];
  assign off_ext  = PC_W'(off);
  assign jmp_tgt  = PC_W'(field);
  assign at_limit = (cycles_q == CNT_W'(MAX_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_addr] <= lut_din;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          pc_d      = '0;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        if (at_limit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycles_d = cycles_q + CNT_W'(1);
          if (stall)        pc_d = pc_q;
          else if (is_halt) state_d = S_DONE;
          else if (is_jmp)  pc_d = jmp_tgt;
          else if (taken)   pc_d = pc_q + off_ext;
          else              pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign pc      = pc_q;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed-vector bench for pc_seq: halt, branches, wrap, watchdog, stall,
// async reset and LUT write/read ordering, with a small program in imem.
module tb_pc_seq;
  localparam int PC_W = 8, INST_W = 9, LUT_AW = 2, OFF_W = 8, CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, stall, z, neg, lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [OFF_W-1:0]  lut_din;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   pc;
  logic              running, done, timeout;
  logic [CNT_W-1:0]  cycles;
  logic [INST_W-1:0] imem [256];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [INST_W-1:0] ALU  = 9'h020;
  localparam logic [INST_W-1:0] HALT = 9'h140;

  pc_seq #(.PC_W(PC_W), .INST_W(INST_W), .OP_W(4), .LUT_AW(LUT_AW), .OFF_W(OFF_W),
           .CNT_W(CNT_W), .MAX_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .inst(inst),
    .z(z), .neg(neg), .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din),
    .pc(pc), .running(running), .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;
  assign inst = imem[pc];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic lut_wr(input logic [LUT_AW-1:0] a, input logic [OFF_W-1:0] d);
    lut_we = 1'b1; lut_addr = a; lut_din = d;
    step();
    lut_we = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; stall = 1'b0; z = 1'b0; neg = 1'b0;
    lut_we = 1'b0; lut_addr = '0; lut_din = '0;
    for (int i = 0; i < 256; i++) imem[i] = ALU;
    #12 reset = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_run", running, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout, 0);
    chk("rst_cyc", cycles, 0);

    // T2: five ALU ops then halt at pc 5
    imem[5] = HALT;
    go();
    chk("t2_run", running, 1);
    chk("t2_pc0", pc, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t2_pc", pc, i);
      chk("t2_ndone", done, 0);
    end
    step();
    chk("t2_done", done, 1);
    chk("t2_nrun", running, 0);
    chk("t2_cyc", cycles, 6);
    chk("t2_to", timeout, 0);
    chk("t2_pch", pc, 5);
    step();
    chk("t2_hold_pc", pc, 5);
    chk("t2_hold_done", done, 1);

    // T1: reset mid-run at pc 0x23
    imem[0] = 9'h15F;
    go();
    for (int i = 0; i < 5; i++) step();
    chk("t1_pc23", pc, 8'h23);
    chk("t1_run", running, 1);
    reset = 1'b1;
    #1;
    chk("t1_pc", pc, 0);
    chk("t1_run0", running, 0);
    chk("t1_done", done, 0);
    chk("t1_cyc", cycles, 0);
    reset = 1'b0;
    step(); step();
    chk("t1_idle_run", running, 0);
    chk("t1_idle_pc", pc, 0);

    // T3/T4: branch taken/untaken, backward wrap, forward wrap, jmp
    lut_wr(2, 8'hFD);
    lut_wr(1, 8'h04);
    lut_wr(3, 8'hEF);
    lut_wr(0, 8'h05);
    imem[0] = 9'h14A; imem[10] = 9'h102; imem[11] = 9'h123;
    imem[250] = 9'h121; imem[254] = 9'h100; imem[3] = 9'h15F; imem[31] = HALT;
    z = 1'b1; neg = 1'b1;
    go();
    step(); chk("t3_jmp10", pc, 10);
    step(); chk("t3_brz_t", pc, 7);
    step(); step(); step();
    chk("t3_pc10", pc, 10);
    z = 1'b0;
    step(); chk("t3_brz_nt", pc, 11);
    z = 1'b1;
    step(); chk("t3_brn_wrap", pc, 250);
    step(); chk("t3_brn", pc, 254);
    step(); chk("t4_wrap", pc, 3);
    step(); chk("t4_jmp31", pc, 31);
    step(); chk("t4_done", done, 1);
    chk("t4_cyc", cycles, 11);

    // T5: endless loop with a 3-cycle stall, ends by watchdog
    imem[0] = ALU; imem[1] = ALU; imem[2] = ALU; imem[3] = 9'h141;
    go();
    chk("t5_to_clr", timeout, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t5_loop", pc, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_pc", pc, 1);
      chk("t5_stall_cyc", cycles, 5 + i);
    end
    stall = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("t5_edges", n, 14);
    chk("t5_to", timeout, 1);
    chk("t5_cyc", cycles, 20);
    step();
    chk("t5_frozen", cycles, 20);

    // T6: LUT write coincident with a branch through the same index
    imem[0] = 9'h101; imem[4] = 9'h101; imem[12] = HALT;
    go();
    chk("t6_to_clr", timeout, 0);
    lut_we = 1'b1; lut_addr = 1; lut_din = 8'h08;
    step();
    lut_we = 1'b0;
    chk("t6_old", pc, 4);
    step(); chk("t6_new", pc, 12);
    step(); chk("t6_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
